// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_ctrl
// Summary  : Multi-cycle instruction fetch controller. It issues one imem
//            request at a time and holds the returned word for decode under a
//            valid/ready handshake. The next fetch starts only after the
//            commit side supplies the next PC. A misaligned next PC produces
//            a faulted slot with no memory access.
// Options  : IFU_TIMEOUT_EN - when defined, a RESP watchdog turns a missing
//            response into a faulted slot after TIMEOUT cycles. The late
//            response is then swallowed through a stale flag.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_ctrl #(
  parameter int unsigned      PC_DW    = 32,
  parameter int unsigned      INST_DW  = 32,
  parameter logic [PC_DW-1:0] RESET_PC = PC_DW'(32'h8000_0000),
  parameter int unsigned      TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_DW-1:0]   imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INST_DW-1:0] imem_resp_data,
  input  logic               imem_resp_err,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INST_DW-1:0] inst,
  output logic [PC_DW-1:0]   inst_pc,
  output logic               inst_err,
  input  logic               commit_valid,
  input  logic [PC_DW-1:0]   commit_next_pc
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_REQ    = 3'd1;
  localparam logic [2:0] c_ST_RESP   = 3'd2;
  localparam logic [2:0] c_ST_OUT    = 3'd3;
  localparam logic [2:0] c_ST_COMMIT = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [PC_DW-1:0]   pc_q, pc_d;
  logic [INST_DW-1:0] inst_q, inst_d;
  logic [PC_DW-1:0]   inst_pc_q, inst_pc_d;
  logic               inst_err_q, inst_err_d;

  logic               w_req_valid;
  logic               w_timeout;
  logic               w_commit_take;
  logic               w_misaligned;

  assign w_misaligned = (commit_next_pc[1:0] != 2'b00);

`ifdef IFU_TIMEOUT_EN
  localparam int unsigned        c_CNT_W    = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  logic [c_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic               stale_q, stale_d;

  // Watchdog counter: zero outside RESP, so each RESP visit starts from zero.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == c_ST_RESP) begin
      tmo_cnt_d = tmo_cnt_q + c_CNT_W'(1);
    end
  end

  // An abandoned fetch leaves one response owed; swallow it before re-requesting.
  always_comb begin
    stale_d = stale_q;
    if (w_timeout) begin
      stale_d = 1'b1;
    end else if (stale_q && imem_resp_valid) begin
      stale_d = 1'b0;
    end
  end

  assign w_timeout   = (state_q == c_ST_RESP) && !imem_resp_valid && (tmo_cnt_q == c_CNT_LAST);
  assign w_req_valid = (state_q == c_ST_REQ) && !stale_q;

  // Watchdog state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      stale_q   <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      stale_q   <= stale_d;
    end
  end
`else
  // Without the watchdog RESP waits forever; TIMEOUT is kept only so both
  // builds share one parameter list.
  assign w_timeout   = 1'b0 && (TIMEOUT != 0);
  assign w_req_valid = (state_q == c_ST_REQ);
`endif

  // Next-state, PC and output-slot update for the fetch sequence.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    inst_err_d    = inst_err_q;
    w_commit_take = 1'b0;

    case (state_q)
      c_ST_IDLE: begin
        state_d = c_ST_REQ;
      end
      c_ST_REQ: begin
        if (w_req_valid && imem_req_ready) begin
          state_d = c_ST_RESP;
        end
      end
      c_ST_RESP: begin
        if (imem_resp_valid) begin
          inst_d     = imem_resp_data;
          inst_err_d = imem_resp_err;
          inst_pc_d  = pc_q;
          state_d    = c_ST_OUT;
        end else if (w_timeout) begin
          inst_d     = '0;
          inst_err_d = 1'b1;
          inst_pc_d  = pc_q;
          state_d    = c_ST_OUT;
        end
      end
      c_ST_OUT: begin
        if (inst_ready) begin
          if (commit_valid) begin
            w_commit_take = 1'b1;
          end else begin
            state_d = c_ST_COMMIT;
          end
        end
      end
      c_ST_COMMIT: begin
        if (commit_valid) begin
          w_commit_take = 1'b1;
        end
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase

    // A misaligned target never reaches memory: it becomes a faulted slot.
    if (w_commit_take) begin
      pc_d = commit_next_pc;
      if (w_misaligned) begin
        inst_d     = '0;
        inst_err_d = 1'b1;
        inst_pc_d  = commit_next_pc;
        state_d    = c_ST_OUT;
      end else begin
        state_d    = c_ST_REQ;
      end
    end
  end

  // Architectural registers of the fetch controller.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= c_ST_IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      inst_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      inst_err_q <= inst_err_d;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == c_ST_OUT);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_err       = inst_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch_ctrl
// Summary  : Scoreboard bench for ifu_fetch_ctrl. It uses a random memory
//            model, random decode/commit behaviour and a slot-level reference
//            model. Define IFU_TIMEOUT_EN to exercise the watchdog with
//            TIMEOUT = 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RST_PC    = 32'h8000_0000;
  localparam logic [31:0] ERR_ADDR  = 32'h8000_0100;
  localparam logic [31:0] HANG_ADDR = 32'h8000_0200;
`ifdef IFU_TIMEOUT_EN
  localparam int TMO    = 8;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid, imem_resp_err;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready, inst_err;
  logic [31:0] inst, inst_pc;
  logic        commit_valid;
  logic [31:0] commit_next_pc;

  always #5 clk = ~clk;

  ifu_fetch_ctrl #(
    .RESET_PC (RST_PC),
    .TIMEOUT  (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_err        (inst_err),
    .commit_valid    (commit_valid),
    .commit_next_pc  (commit_next_pc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } slot_t;

  slot_t       exp_slot_q[$];
  logic [31:0] exp_req_q[$];

  // Memory contents and fault map, as functions of the address.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == ERR_ADDR) return 32'hDEAD_BEEF;
    if (a == RST_PC)   return 32'h0000_0013;
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a == ERR_ADDR) || (a[7:2] == 6'h3F);
  endfunction

  // Reference model: what decode must see for a fetch slot at a given pc.
  function automatic slot_t expect_slot(input logic [31:0] pc);
    slot_t s;
    s.pc = pc;
    if (pc[1:0] != 2'b00) begin
      s.inst = 32'h0;
      s.err  = 1'b1;
    end else if (TMO_EN && pc == HANG_ADDR) begin
      s.inst = 32'h0;
      s.err  = 1'b1;
    end else begin
      s.inst = mem_data(pc);
      s.err  = mem_err(pc);
    end
    return s;
  endfunction

  task automatic expect_fetch(input logic [31:0] pc);
    exp_slot_q.push_back(expect_slot(pc));
    if (pc[1:0] == 2'b00) exp_req_q.push_back(pc);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b", name, act, req);
    end
  endtask

  task automatic finish_sim();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic check_reset_vals();
    checkb("rst_req_valid",  imem_req_valid, 1'b0);
    check ("rst_req_addr",   imem_req_addr,  RST_PC);
    checkb("rst_inst_valid", inst_valid,     1'b0);
    checkb("rst_inst_err",   inst_err,       1'b0);
    check ("rst_inst",       inst,           32'h0);
    check ("rst_inst_pc",    inst_pc,        32'h0);
  endtask

  // ---------------------------------------------------------------- memory
  logic        mem_busy   = 1'b0;
  logic        true_resp  = 1'b0;
  int          mem_delay  = 0;
  int          stall_req  = 0;
  logic [31:0] mem_addr   = 32'h0;

  initial begin
    logic        hs;
    logic [31:0] a;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      hs = rst && imem_req_valid && imem_req_ready;
      a  = imem_req_addr;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      imem_resp_err   = 1'b0;
      imem_resp_data  = $urandom;
      true_resp       = 1'b0;
      if (hs) begin
        mem_busy  = 1'b1;
        mem_addr  = a;
        mem_delay = (TMO_EN && a == HANG_ADDR) ? TMO + 4 : int'($urandom_range(0, 3));
      end
      if (mem_busy) begin
        if (mem_delay == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_data(mem_addr);
          imem_resp_err   = mem_err(mem_addr);
          true_resp       = !(TMO_EN && mem_addr == HANG_ADDR);
          mem_busy        = 1'b0;
        end else begin
          mem_delay--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_0BAD;
        imem_resp_err   = 1'($urandom_range(0, 1));
      end
      if (stall_req > 0) begin
        stall_req--;
        imem_req_ready = 1'b0;
      end else begin
        imem_req_ready = ($urandom_range(0, 99) < 65);
      end
    end
  end

  // ---------------------------------------------------------------- monitor
  initial begin
    logic        p_req_pend;
    logic        p_hs;
    logic        p_true;
    logic        hang_wait;
    logic [31:0] p_addr;
    logic [31:0] ra;
    int          since_hs;
    slot_t       s;
    p_req_pend = 1'b0;
    p_hs       = 1'b0;
    p_true     = 1'b0;
    hang_wait  = 1'b0;
    p_addr     = 32'h0;
    since_hs   = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        p_req_pend = 1'b0;
        p_hs       = 1'b0;
        p_true     = 1'b0;
        hang_wait  = 1'b0;
        continue;
      end
      if (p_req_pend) begin
        checkb("req_held_until_hs", imem_req_valid, 1'b1);
        check ("req_addr_stable",   imem_req_addr,  p_addr);
      end
      if (p_hs)     checkb("req_drops_after_hs", imem_req_valid, 1'b0);
      if (mem_busy) checkb("one_fetch_in_flight", imem_req_valid, 1'b0);
      if (imem_req_valid && imem_req_ready) begin
        if (exp_req_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: actual addr %h required no request", imem_req_addr);
        end else begin
          ra = exp_req_q.pop_front();
          check("req_addr", imem_req_addr, ra);
        end
        hang_wait = TMO_EN && (imem_req_addr == HANG_ADDR);
        since_hs  = 0;
      end
      if (p_true) checkb("valid_after_resp", inst_valid, 1'b1);
      if (inst_valid) begin
        if (exp_slot_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_inst: actual pc %h required no slot", inst_pc);
        end else begin
          s = exp_slot_q[0];
          check ("inst",     inst,     s.inst);
          check ("inst_pc",  inst_pc,  s.pc);
          checkb("inst_err", inst_err, s.err);
          if (inst_ready) void'(exp_slot_q.pop_front());
        end
        if (hang_wait) begin
          check("timeout_latency", 32'(since_hs), 32'(TMO + 1));
          hang_wait = 1'b0;
        end
      end
      since_hs++;
      p_req_pend = imem_req_valid && !imem_req_ready;
      p_hs       = imem_req_valid && imem_req_ready;
      p_addr     = imem_req_addr;
      p_true     = true_resp;
    end
  end

  // ---------------------------------------------------------------- decode / commit driver
  function automatic logic [31:0] pick_next(input logic [31:0] pc);
    int unsigned r;
    logic [31:0] base;
    r    = $urandom_range(0, 99);
    base = (pc & 32'hFFFF_FFFC) + 32'd4;
    if (r < 55) return base;
    if (r < 80) return RST_PC + {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    if (r < 90) return base + 32'($urandom_range(1, 3));
    return ERR_ADDR;
  endfunction

  task automatic run_insts(input int n, input bit directed, input logic [31:0] start_pc);
    logic [31:0] pc;
    logic [31:0] nxt;
    logic [31:0] dlist [4];
    int          guard;
    int          stalls;
    dlist[0] = 32'h8000_0010;
    dlist[1] = 32'h8000_0006;
    dlist[2] = ERR_ADDR;
    dlist[3] = TMO_EN ? HANG_ADDR : 32'h8000_0020;
    pc = start_pc;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (!inst_valid) begin
        if (guard++ > 100) begin
          n_checks++;
          n_fail++;
          $display("FAIL inst_valid_timeout: actual 0 required 1 within 100 cycles");
          finish_sim();
        end
        commit_valid   = ($urandom_range(0, 3) == 0);
        commit_next_pc = $urandom;
        inst_ready     = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      stalls = (directed && i == 0) ? 4 : int'($urandom_range(0, 3));
      repeat (stalls) begin
        inst_ready     = 1'b0;
        commit_valid   = 1'($urandom_range(0, 1));
        commit_next_pc = $urandom;
        @(posedge clk);
        #1;
      end
      if (directed && i < 4)  nxt = dlist[i];
      else if (i == n - 1)    nxt = RST_PC + 32'h40;
      else                    nxt = pick_next(pc);
      inst_ready = 1'b1;
      if ($urandom_range(0, 1) == 1 || (directed && i == 0)) begin
        commit_valid   = 1'b1;
        commit_next_pc = nxt;
        if (directed && i == 0) stall_req = 6;
        @(posedge clk);
        #1;
      end else begin
        commit_valid = 1'b0;
        @(posedge clk);
        #1;
        repeat ($urandom_range(0, 2)) begin
          commit_valid = 1'b0;
          inst_ready   = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        commit_valid   = 1'b1;
        commit_next_pc = nxt;
        inst_ready     = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      expect_fetch(nxt);
      if (!(TMO_EN && pc == HANG_ADDR)) begin
        if (nxt[1:0] != 2'b00) begin
          checkb("misaligned_no_req", imem_req_valid, 1'b0);
          checkb("misaligned_to_out", inst_valid,     1'b1);
        end else begin
          checkb("req_after_commit",      imem_req_valid, 1'b1);
          check ("req_addr_after_commit", imem_req_addr,  nxt);
        end
      end
      pc             = nxt;
      commit_valid   = 1'b0;
      inst_ready     = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------- main sequence
  initial begin
    int guard;
    inst_ready     = 1'b0;
    commit_valid   = 1'b0;
    commit_next_pc = 32'h0;
    rst            = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    expect_fetch(RST_PC);
    rst = 1'b1;
    @(negedge clk);
    checkb("req_valid_after_idle", imem_req_valid, 1'b1);
    check ("first_req_addr",       imem_req_addr,  RST_PC);

    run_insts(120, 1'b1, RST_PC);

    // Reset while a fetch is in flight.
    guard = 0;
    do begin
      @(posedge clk);
      #2;
      if (guard++ > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL fetch_in_flight_timeout: actual 0 required 1 within 50 cycles");
        finish_sim();
      end
    end while (!mem_busy);
    rst = 1'b0;
    exp_slot_q.delete();
    exp_req_q.delete();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    expect_fetch(RST_PC);
    rst = 1'b1;

    run_insts(60, 1'b0, RST_PC);
    repeat (20) @(posedge clk);
    finish_sim();
  end

  initial begin
    #1_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete in time");
    finish_sim();
  end

endmodule
`default_nettype wire
